result_fifo_bank: RTL and testbench

RESULT_FIFO_BANK -- requirements
Module: result_fifo_bank

---
 rtl/result_fifo_bank.sv | 125 ++++++++++++
 tb/tb_result_fifo_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_fifo_bank.sv
// rtl/result_fifo_bank.sv - bank of per-channel result FIFOs drained through a 32-bit register bus
// Pops happen in the read cycle itself; the head word is sampled into readdata on that edge.
module result_fifo_bank #(
  parameter int NUM_CH    = 3,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4096,
  parameter int SKIP_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [4:0]               address,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        empty,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic                     w_rd_cycle;
  logic                     w_wr_cycle;
  logic [NUM_CH-1:0]        w_pop;
  logic [NUM_CH-1:0]        w_flush;
  logic [NUM_CH-1:0]        w_ovf_set;
  logic [NUM_CH-1:0]        w_ovf_clr;
  logic [NUM_CH*CW-1:0]     w_count_flat;
  logic [NUM_CH*DATA_W-1:0] w_head_flat;
  logic [31:0]              w_rdata_next;
  logic [NUM_CH-1:0]        r_ovf;
  logic [7:0]               r_mask;
  logic [31:0]              r_readdata;

  assign w_rd_cycle = chipselect & read;
  assign w_wr_cycle = chipselect & write;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] w_word;
    logic              w_push_req;
    logic              w_push;
    logic              w_is_full;

    assign w_word     = wr_data[gi*DATA_W +: DATA_W];
    assign w_push_req = wr_en[gi] && !((SKIP_ZERO != 0) && (w_word == '0));
    assign w_is_full  = (r_count == CW'(DEPTH));
    assign w_pop[gi]  = w_rd_cycle && (address == 5'(gi)) && (r_count != '0);
    assign w_flush[gi] = w_wr_cycle && (address == 5'd19) && writedata[gi];
    // A same-cycle pop frees the slot, so a full channel still accepts the push.
    assign w_push        = w_push_req && !w_flush[gi] && (!w_is_full || w_pop[gi]);
    assign w_ovf_set[gi] = w_push_req && !w_flush[gi] && w_is_full && !w_pop[gi];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (w_flush[gi]) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop[gi]);
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    assign w_count_flat[gi*CW +: CW]         = r_count;
    assign w_head_flat[gi*DATA_W +: DATA_W]  = r_mem[r_rd_ptr];
    assign full[gi]  = w_is_full;
    assign empty[gi] = (r_count == '0);
  end

  always_comb begin
    w_rdata_next = 32'h0000_00FB;
    if (w_rd_cycle) begin
      w_rdata_next = 32'h0000_00FC;
      for (int i = 0; i < NUM_CH; i++) begin
        if (address == 5'(i))
          w_rdata_next = empty[i] ? 32'h0000_00FF : 32'(w_head_flat[i*DATA_W +: DATA_W]);
        if (address == 5'(8 + i))
          w_rdata_next = 32'(w_count_flat[i*CW +: CW]);
      end
      case (address)
        5'd16:   w_rdata_next = {16'h0, 8'(full), 8'(empty)};
        5'd17:   w_rdata_next = {24'h0, 8'(r_ovf)};
        5'd18:   w_rdata_next = {24'h0, r_mask};
        default: ;
      endcase
    end
  end

  assign w_ovf_clr = (w_wr_cycle && address == 5'd17) ? writedata[NUM_CH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf      <= '0;
      r_mask     <= '0;
      r_readdata <= 32'h0000_00FB;
    end else begin
      // Set is OR-ed after the clear so a fresh overflow survives a same-cycle W1C.
      r_ovf      <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
      if (w_wr_cycle && address == 5'd18) r_mask <= writedata[7:0];
      r_readdata <= w_rdata_next;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_ovf & r_mask[NUM_CH-1:0]);

endmodule

// File: tb/tb_result_fifo_bank.sv
// tb/tb_result_fifo_bank.sv - directed and randomized checks of result_fifo_bank against a queue model
module tb_result_fifo_bank;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  wr_en;
  logic [95:0] wr_data;
  logic        chipselect, read, write;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [2:0]  full, empty;
  logic        irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] q [NUM_CH][$];
  logic [2:0]  m_ovf;
  logic [7:0]  m_mask;
  logic [31:0] exp_rdata;

  result_fifo_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .SKIP_ZERO(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .full(full), .empty(empty), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] pk(input int c, input logic [31:0] v);
    logic [95:0] r;
    r = '0;
    r[c*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [2:0] m_full();
    logic [2:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (q[c].size() == DEPTH);
    return r;
  endfunction

  function automatic logic [2:0] m_empty();
    logic [2:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (q[c].size() == 0);
    return r;
  endfunction

  function automatic logic m_irq();
    return |(m_ovf & m_mask[2:0]);
  endfunction

  task automatic set_idle();
    wr_en = '0; wr_data = '0; chipselect = 0; read = 0; write = 0; address = '0; writedata = '0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) q[c].delete();
    m_ovf = '0; m_mask = '0;
  endtask

  // Drives one clock of stimulus, advances the model, returns #1 after the edge.
  task automatic step(input logic [2:0] we, input logic [95:0] wd, input logic cs,
                      input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] wdat);
    logic rdc, wrc;
    logic [2:0] flush, set, clr;
    logic [31:0] d, tmp;
    wr_en = we; wr_data = wd; chipselect = cs; read = rd; write = wr; address = a; writedata = wdat;
    rdc = cs & rd; wrc = cs & wr;
    if (!rdc) exp_rdata = 32'hFB;
    else if (a < 3) exp_rdata = (q[a].size() > 0) ? q[a][0] : 32'hFF;
    else if (a >= 8 && a < 11) exp_rdata = q[a-8].size();
    else if (a == 16) exp_rdata = {16'h0, 5'h0, m_full(), 5'h0, m_empty()};
    else if (a == 17) exp_rdata = {29'h0, m_ovf};
    else if (a == 18) exp_rdata = {24'h0, m_mask};
    else exp_rdata = 32'hFC;
    if (rdc && a < 3 && q[a].size() > 0) tmp = q[a].pop_front();
    flush = (wrc && a == 19) ? wdat[2:0] : 3'b0;
    clr   = (wrc && a == 17) ? wdat[2:0] : 3'b0;
    set   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      d = wd[c*32 +: 32];
      if (flush[c]) q[c].delete();
      else if (we[c] && d != 0) begin
        if (q[c].size() < DEPTH) q[c].push_back(d);
        else set[c] = 1'b1;
      end
    end
    m_ovf = (m_ovf & ~clr) | set;
    if (wrc && a == 18) m_mask = wdat[7:0];
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    #1;
    checks++; if (readdata !== 32'hFB) begin errors++; $display("FAIL reset_rdata got=%h want=%h", readdata, 32'hFB); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 3'b111) begin errors++; $display("FAIL reset_empty got=%b want=111", empty); end
    checks++; if (full !== 3'b000) begin errors++; $display("FAIL reset_full got=%b want=000", full); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic_pop();
    logic [31:0] want [4];
    want = '{32'h11, 32'h22, 32'h33, 32'hFF};
    step(3'b001, pk(0, 32'h11), 0, 0, 0, 0, 0);
    checks++; if (readdata !== 32'hFB) begin errors++; $display("FAIL idle_rdata got=%h want=%h", readdata, 32'hFB); end
    step(3'b001, pk(0, 32'h22), 0, 0, 0, 0, 0);
    step(3'b001, pk(0, 32'h33), 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 1, 0, 5'd0, 0);
      checks++; if (readdata !== want[k]) begin errors++; $display("FAIL basic_pop%0d got=%h want=%h", k, readdata, want[k]); end
    end
    step(0, 0, 1, 1, 0, 5'd8, 0);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL basic_count got=%h want=0", readdata); end
  endtask

  task automatic test_skip_zero();
    step(3'b010, pk(1, 32'h0), 0, 0, 0, 0, 0);
    step(3'b010, pk(1, 32'h5), 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 5'd9, 0);
    checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL skip_count got=%h want=1", readdata); end
    step(0, 0, 1, 1, 0, 5'd1, 0);
    checks++; if (readdata !== 32'h5) begin errors++; $display("FAIL skip_data got=%h want=5", readdata); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) step(3'b100, pk(2, 32'h101 + k), 0, 0, 0, 0, 0);
    checks++; if (full[2] !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b want=1", full[2]); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_masked got=%b want=0", irq); end
    step(0, 0, 1, 1, 0, 5'd17, 0);
    checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL ovf_flag got=%h want=4", readdata); end
    step(0, 0, 1, 0, 1, 5'd18, 32'h4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq got=%b want=1", irq); end
    step(0, 0, 1, 1, 1, 5'd17, 32'h4);
    checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL rw_prewrite got=%h want=4", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_clr got=%b want=0", irq); end
    step(3'b100, pk(2, 32'h106), 1, 0, 1, 5'd17, 32'h4);
    step(0, 0, 1, 1, 0, 5'd17, 0);
    checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL set_wins got=%h want=4", readdata); end
    step(0, 0, 1, 0, 1, 5'd17, 32'h4);
    step(0, 0, 1, 1, 0, 5'd17, 0);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL ovf_cleared got=%h want=0", readdata); end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 1, 0, 5'd2, 0);
      checks++;
      if (readdata !== ((k < 4) ? 32'h101 + k : 32'hFF)) begin
        errors++; $display("FAIL ovf_drain%0d got=%h want=%h", k, readdata, (k < 4) ? 32'h101 + k : 32'hFF);
      end
    end
    step(0, 0, 1, 1, 0, 5'd18, 0);
    checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL mask_read got=%h want=4", readdata); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] want [5];
    want = '{32'hA2, 32'hA3, 32'hA4, 32'hAA, 32'hFF};
    for (int k = 0; k < 4; k++) step(3'b001, pk(0, 32'hA1 + k), 0, 0, 0, 0, 0);
    step(3'b001, pk(0, 32'hAA), 1, 1, 0, 5'd0, 0);
    checks++; if (readdata !== 32'hA1) begin errors++; $display("FAIL fullpp_pop got=%h want=A1", readdata); end
    step(0, 0, 1, 1, 0, 5'd8, 0);
    checks++; if (readdata !== 32'h4) begin errors++; $display("FAIL fullpp_count got=%h want=4", readdata); end
    step(0, 0, 1, 1, 0, 5'd17, 0);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL fullpp_ovf got=%h want=0", readdata); end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 1, 0, 5'd0, 0);
      checks++; if (readdata !== want[k]) begin errors++; $display("FAIL fullpp_drain%0d got=%h want=%h", k, readdata, want[k]); end
    end
    step(3'b001, pk(0, 32'h77), 1, 1, 0, 5'd0, 0);
    checks++; if (readdata !== 32'hFF) begin errors++; $display("FAIL emptypp_pop got=%h want=FF", readdata); end
    step(0, 0, 1, 1, 0, 5'd8, 0);
    checks++; if (readdata !== 32'h1) begin errors++; $display("FAIL emptypp_count got=%h want=1", readdata); end
    step(0, 0, 1, 1, 0, 5'd0, 0);
    checks++; if (readdata !== 32'h77) begin errors++; $display("FAIL emptypp_data got=%h want=77", readdata); end
  endtask

  task automatic test_reset_mid();
    step(3'b001, pk(0, 32'h1234), 0, 0, 0, 0, 0);
    step(3'b001, pk(0, 32'h5678), 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 5'd16, 0);
    chipselect = 1; read = 1; address = 5'd0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (readdata !== 32'hFB) begin errors++; $display("FAIL rstmid_rdata got=%h want=FB", readdata); end
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL rstmid_empty got=%b want=1", empty[0]); end
    @(posedge clk); #1;
    set_idle();
    reset = 1'b0;
    model_clear();
    step(0, 0, 1, 1, 0, 5'd0, 0);
    checks++; if (readdata !== 32'hFF) begin errors++; $display("FAIL rstmid_pop got=%h want=FF", readdata); end
    step(0, 0, 1, 1, 0, 5'd18, 0);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rstmid_mask got=%h want=0", readdata); end
  endtask

  task automatic test_misc();
    step(0, 0, 1, 1, 0, 5'd5, 0);
    checks++; if (readdata !== 32'hFC) begin errors++; $display("FAIL bad_addr got=%h want=FC", readdata); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++; if (readdata !== 32'hFB) begin errors++; $display("FAIL idle got=%h want=FB", readdata); end
    step(3'b010, pk(1, 32'h9), 0, 0, 0, 0, 0);
    step(3'b010, pk(1, 32'hA), 0, 0, 0, 0, 0);
    step(3'b010, pk(1, 32'hB), 1, 0, 1, 5'd19, 32'h2);
    step(0, 0, 1, 1, 0, 5'd9, 0);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL flush_count got=%h want=0", readdata); end
    step(0, 0, 1, 1, 0, 5'd17, 0);
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL flush_noovf got=%h want=0", readdata); end
    step(0, 0, 1, 1, 0, 5'd16, 0);
    checks++; if (readdata !== 32'h7) begin errors++; $display("FAIL status got=%h want=7", readdata); end
  endtask

  task automatic test_random();
    logic [4:0] atab [12];
    logic [95:0] wd;
    logic [4:0] a;
    atab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd5};
    for (int n = 0; n < 600; n++) begin
      wd = '0;
      for (int c = 0; c < NUM_CH; c++)
        wd[c*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : atab[$urandom_range(0, 11)];
      step(3'($urandom), wd, ($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
           a, ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 7)));
      checks++; if (readdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata n=%0d got=%h want=%h", n, readdata, exp_rdata); end
      checks++; if (full !== m_full()) begin errors++; $display("FAIL rand_full n=%0d got=%b want=%b", n, full, m_full()); end
      checks++; if (empty !== m_empty()) begin errors++; $display("FAIL rand_empty n=%0d got=%b want=%b", n, empty, m_empty()); end
      checks++; if (irq !== m_irq()) begin errors++; $display("FAIL rand_irq n=%0d got=%b want=%b", n, irq, m_irq()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pop();
    test_skip_zero();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_misc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
